// File: rtl/vga_pixel_fifo.sv
// ---------------------------------------------------------------------------
// vga_pixel_fifo
//   Elastic 24-bit RGB pixel buffer sitting directly upstream of the VGA
//   colour outputs. A producer pushes pixels with a valid/ready handshake;
//   the display side pops one pixel per active-area cycle (pixel_valid) and
//   sees it on registered r/g/b exactly one clock later. A pop from an empty
//   buffer drives black and sets a sticky underflow flag.
//
// Ports
//   clk            pixel clock, sole clock domain
//   reset          asynchronous reset, active low
//   in_valid       producer has a pixel on in_data
//   in_ready       buffer accepts a pixel this cycle (level != DEPTH)
//   in_data        pixel {r[23:16], g[15:8], b[7:0]}
//   pixel_valid    pop request from the sync generator (active area)
//   r, g, b        registered colour outputs
//   out_valid      r/g/b carry a pixel popped (or blanked) last cycle
//   level          current occupancy, 0..DEPTH
//   almost_empty   level <= LOW_WATER
//   underflow      sticky, set by a pop from empty
//   underflow_clr  clears underflow (a same-cycle underflow wins)
// ---------------------------------------------------------------------------
module vga_pixel_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int LOW_WATER = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [23:0]   in_data,
  input  logic          pixel_valid,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic          out_valid,
  output logic [AW:0]   level,
  output logic          almost_empty,
  output logic          underflow,
  input  logic          underflow_clr
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0] LOW_LVL  = LOW_WATER[AW:0];
  localparam logic [AW:0] LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  // storage: contents are don't-care after reset, so no reset on the array
  logic [23:0]   r_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_rst_done;   // low while in reset, high from first clock after
  logic [23:0]   r_pix;
  logic          r_out_valid;
  logic          r_underflow;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_uflow_evt;

  // full/empty come from the level counter only; pointers just wrap
  assign w_full      = (r_level == FULL_LVL);
  assign w_empty     = (r_level == '0);

  // ready is a pure decode of registered state: no look-ahead on a pop
  assign in_ready    = r_rst_done & ~w_full;
  assign w_push      = in_valid & in_ready;
  assign w_pop       = pixel_valid & ~w_empty;
  // empty-cycle pop request; a same-cycle push does not fall through
  assign w_uflow_evt = pixel_valid & w_empty;

  // ---------------------------------------------------------------------
  // write port
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // ---------------------------------------------------------------------
  // pointers and occupancy
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // pop side: registered colour, blank on idle and on underflow
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= pixel_valid;
      if (w_pop) r_pix <= r_mem[r_rd_ptr];
      else       r_pix <= '0;
    end
  end

  // sticky error: set has priority over clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_underflow <= 1'b0;
    end else if (w_uflow_evt) begin
      r_underflow <= 1'b1;
    end else if (underflow_clr) begin
      r_underflow <= 1'b0;
    end
  end

  assign r            = r_pix[23:16];
  assign g            = r_pix[15:8];
  assign b            = r_pix[7:0];
  assign out_valid    = r_out_valid;
  assign level        = r_level;
  assign almost_empty = (r_level <= LOW_LVL);
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
module tb_vga_pixel_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        underflow_clr = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_ready, out_valid, almost_empty, underflow;
  logic [7:0]  r, g, b;
  logic [AW:0] level;

  vga_pixel_fifo #(.DEPTH(DEPTH), .AW(AW), .LOW_WATER(LW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .pixel_valid(pixel_valid), .r(r), .g(g), .b(b),
    .out_valid(out_valid), .level(level), .almost_empty(almost_empty),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // ---------------- behavioural model: a queue of pixels ----------------
  logic [23:0] mq[$];
  bit          m_rdy = 0;
  bit          m_ov = 0;
  logic [23:0] m_rgb = '0;
  bit          m_uf = 0;

  always @(posedge clk or negedge reset) begin
    bit do_push, was_empty;
    if (!reset) begin
      mq.delete();
      m_rdy = 0; m_ov = 0; m_rgb = '0; m_uf = 0;
    end else begin
      was_empty = (mq.size() == 0);
      do_push   = in_valid && m_rdy && (mq.size() < DEPTH);
      if (pixel_valid) begin
        m_ov = 1;
        if (!was_empty) m_rgb = mq.pop_front();
        else            m_rgb = '0;
      end else begin
        m_ov = 0;
        m_rgb = '0;
      end
      if (pixel_valid && was_empty) m_uf = 1;
      else if (underflow_clr)       m_uf = 0;
      if (do_push) mq.push_back(in_data);
      m_rdy = 1;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  bit chk_en = 0;
  always @(negedge clk) begin
    int  e_lvl;
    bit  e_rdy, e_ae;
    if (chk_en) begin
      e_lvl = mq.size();
      e_rdy = m_rdy && (mq.size() < DEPTH);
      e_ae  = (mq.size() <= LW);
      nvec++;
      if (level !== e_lvl[AW:0] || in_ready !== e_rdy || almost_empty !== e_ae ||
          out_valid !== m_ov || {r, g, b} !== m_rgb || underflow !== m_uf) begin
        nerr++;
        $display("FAIL model t=%0t: got lvl=%0d rdy=%0b ae=%0b ov=%0b rgb=%06h uf=%0b, expected lvl=%0d rdy=%0b ae=%0b ov=%0b rgb=%06h uf=%0b",
                 $time, level, in_ready, almost_empty, out_valid, {r, g, b}, underflow,
                 e_lvl, e_rdy, e_ae, m_ov, m_rgb, m_uf);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drive one cycle's inputs at a negedge, return at the following negedge
  task automatic step(input bit iv, input logic [23:0] d, input bit pv, input bit clr);
    in_valid = iv; in_data = d; pixel_valid = pv; underflow_clr = clr;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && level != 0; i++) step(0, '0, 1, 0);
    chk("drain_lvl", level, 0);
    step(0, '0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] d, prev;
    bit          acc;

    // 1. reset
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", in_ready, 0);
    chk("rst_lvl", level, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_rgb", {r, g, b}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_rdy", in_ready, 1);
    chk("rel_lvl", level, 0);
    chk("rel_ae", almost_empty, 1);
    chk("rel_uf", underflow, 0);
    chk("rel_ov", out_valid, 0);
    chk_en = 1;

    // 2. three pixels through, one-clock latency
    step(1, 24'h112233, 0, 0);
    step(1, 24'h445566, 0, 0);
    step(1, 24'h778899, 0, 0);
    chk("t2_lvl3", level, 3);
    step(0, '0, 1, 0);
    chk("t2_p0", {out_valid, r, g, b}, {1'b1, 24'h112233});
    step(0, '0, 1, 0);
    chk("t2_p1", {out_valid, r, g, b}, {1'b1, 24'h445566});
    step(0, '0, 1, 0);
    chk("t2_p2", {out_valid, r, g, b}, {1'b1, 24'h778899});
    step(0, '0, 0, 0);
    chk("t2_lvl0", level, 0);
    chk("t2_idle", {out_valid, r, g, b}, 0);

    // 3. fill to full, overflow attempt rejected, one pop re-opens
    for (int i = 1; i <= DEPTH; i++) step(1, 24'(i), 0, 0);
    chk("t3_full", level, DEPTH);
    chk("t3_rdy0", in_ready, 0);
    step(1, 24'd17, 0, 0);
    chk("t3_nopush", level, DEPTH);
    step(0, '0, 1, 0);
    chk("t3_lvl15", level, DEPTH - 1);
    chk("t3_rdy1", in_ready, 1);
    chk("t3_first", {r, g, b}, 1);
    step(1, 24'd17, 0, 0);
    chk("t3_refull", level, DEPTH);

    // 4. stream from full: strictly incrementing, levels 15..16
    d = 24'd18;
    prev = 24'd1;
    for (int i = 0; i < 40; i++) begin
      acc = in_ready;
      step(1, d, 1, 0);
      if (acc) d = d + 1;
      chk("t4_seq", {out_valid, r, g, b}, {1'b1, prev + 24'd1});
      prev = {r, g, b};
      chk("t4_lvl", (level >= 15 && level <= 16), 1);
    end
    in_valid = 0;
    drain();

    // 5. underflow, set-beats-clear, clear, no fall-through
    step(0, '0, 1, 0);
    chk("t5_blank", {out_valid, r, g, b}, {1'b1, 24'h0});
    chk("t5_uf", underflow, 1);
    step(0, '0, 1, 1);
    chk("t5_setwins", underflow, 1);
    step(0, '0, 0, 1);
    chk("t5_clr", underflow, 0);
    step(1, 24'habcdef, 1, 0);
    chk("t5_nofall_uf", underflow, 1);
    chk("t5_nofall_rgb", {r, g, b}, 0);
    chk("t5_nofall_lvl", level, 1);
    step(0, '0, 1, 1);
    chk("t5_stored", {r, g, b}, 24'habcdef);
    chk("t5_clr2", underflow, 0);

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 10) < 6, 24'($urandom), ($urandom % 10) < 5, ($urandom % 16) == 0);
    end
    in_valid = 0;
    drain();

    // 6. asynchronous reset mid-stream
    for (int i = 0; i < 7; i++) step(1, 24'h600 + 24'(i), 0, 0);
    step(0, '0, 1, 0);
    step(1, 24'h700, 0, 0);
    chk("t6_lvl7", level, 7);
    in_valid = 1; in_data = 24'h701; pixel_valid = 1;
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_lvl", level, 0);
    chk("t6_async_ov", out_valid, 0);
    chk("t6_async_rgb", {r, g, b}, 0);
    chk("t6_async_rdy", in_ready, 0);
    in_valid = 0; pixel_valid = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    step(1, 24'ha1b2c3, 0, 0);
    step(1, 24'hd4e5f6, 0, 0);
    step(0, '0, 1, 0);
    chk("t6_first", {r, g, b}, 24'ha1b2c3);
    step(0, '0, 1, 0);
    chk("t6_second", {r, g, b}, 24'hd4e5f6);
    step(0, '0, 0, 0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
